// File: rtl/sobel_pkg.sv
// Shared constants and types for the sobel read-response reorder path.
package sobel_pkg;
   localparam int SOBEL_DATA_W = 512;
   localparam int SOBEL_TAG_W  = 6;
   localparam int SOBEL_DEPTH  = 2 ** SOBEL_TAG_W;

   typedef logic [SOBEL_TAG_W-1:0] t_rob_tag;
endpackage

// File: rtl/sobel_rd_reorder_if.sv
// Handshake bundle between the read issuer/response path and the reorder buffer.
interface sobel_rd_reorder_if
   import sobel_pkg::*;
#(
   parameter int DATA_W = SOBEL_DATA_W,
   parameter int TAG_W  = SOBEL_TAG_W
);
   logic              clear;
   logic              alloc_valid;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;
   logic              in_valid;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [31:0]       out_seq;
   logic [TAG_W:0]    count;
   logic              err;

   // Reorder buffer side.
   modport slave (
      input  clear, alloc_valid, in_valid, in_tag, in_data, out_ready,
      output alloc_ready, alloc_tag, out_valid, out_data, out_seq, count, err
   );

   // Issuer / response source / consumer side.
   modport master (
      output clear, alloc_valid, in_valid, in_tag, in_data, out_ready,
      input  alloc_ready, alloc_tag, out_valid, out_data, out_seq, count, err
   );
endinterface

// File: rtl/sobel_rob_ram.sv
// Reorder payload storage: one write port, one read port with registered read.
// The read register doubles as the output data register of the reorder buffer,
// so it is cleared on reset/clear and only loads when a read is requested.
module sobel_rob_ram
   import sobel_pkg::*;
#(
   parameter int DATA_W = SOBEL_DATA_W,
   parameter int ADDR_W = SOBEL_TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_reg;

   // Payload write; no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read, held while no new read is requested.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rd_data_reg <= '0;
      else if (clear) rd_data_reg <= '0;
      else if (rd_en) rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;
endmodule

// File: rtl/sobel_rd_reorder.sv
// In-order reassembly of out-of-order c0 read responses. Reads are tagged
// sequentially at issue (tail), responses land in their slot, and lines leave
// strictly in issue order from head through a one-line output register.
module sobel_rd_reorder
   import sobel_pkg::*;
#(
   parameter int DATA_W = SOBEL_DATA_W,
   parameter int TAG_W  = SOBEL_TAG_W
) (
   input logic             clk,
   input logic             reset,
   sobel_rd_reorder_if.slave bus
);
   localparam int             DEPTH = 2 ** TAG_W;
   localparam logic [TAG_W:0] FULL  = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0] head_reg;
   logic [TAG_W-1:0] tail_reg;
   logic [DEPTH-1:0] alloc_reg;
   logic [DEPTH-1:0] filled_reg;
   logic [TAG_W:0]   count_reg;
   logic             out_valid_reg;
   logic [31:0]      seq_reg;
   logic             err_reg;

   logic alloc_ready;
   logic do_alloc;
   logic rsp_ok;
   logic do_write;
   logic do_release;
   logic do_accept;

   // Event decode for this cycle.
   always_comb begin
      alloc_ready = (count_reg < FULL);
      do_alloc    = bus.alloc_valid && alloc_ready;
      rsp_ok      = alloc_reg[bus.in_tag] && !filled_reg[bus.in_tag];
      do_write    = bus.in_valid && rsp_ok;
      do_accept   = out_valid_reg && bus.out_ready;
      do_release  = filled_reg[head_reg] && (!out_valid_reg || bus.out_ready);
   end

   // Pointers, occupancy, output valid, sequence number and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         seq_reg       <= '0;
         err_reg       <= 1'b0;
      end else if (bus.clear) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         seq_reg       <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (do_alloc)   tail_reg <= tail_reg + 1'b1;
         if (do_release) head_reg <= head_reg + 1'b1;
         case ({do_alloc, do_release})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (do_release)     out_valid_reg <= 1'b1;
         else if (do_accept) out_valid_reg <= 1'b0;
         if (do_accept) seq_reg <= seq_reg + 1'b1;
         if (bus.in_valid && !rsp_ok) err_reg <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slot ownership: set when the read is issued, dropped when released.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                                        alloc_reg[gi] <= 1'b0;
         else if (bus.clear)                               alloc_reg[gi] <= 1'b0;
         else if (do_alloc && tail_reg == TAG_W'(gi))      alloc_reg[gi] <= 1'b1;
         else if (do_release && head_reg == TAG_W'(gi))    alloc_reg[gi] <= 1'b0;
      end

      // Slot payload present: set by a valid response, dropped when released.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                                        filled_reg[gi] <= 1'b0;
         else if (bus.clear)                               filled_reg[gi] <= 1'b0;
         else if (do_write && bus.in_tag == TAG_W'(gi))    filled_reg[gi] <= 1'b1;
         else if (do_release && head_reg == TAG_W'(gi))    filled_reg[gi] <= 1'b0;
      end
   end

   // A release reads head into the RAM's output register, which is out_data.
   sobel_rob_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (TAG_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.clear),
      .wr_en   (do_write),
      .wr_addr (bus.in_tag),
      .wr_data (bus.in_data),
      .rd_en   (do_release),
      .rd_addr (head_reg),
      .rd_data (bus.out_data)
   );

   assign bus.alloc_ready = alloc_ready;
   assign bus.alloc_tag   = tail_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_seq     = seq_reg;
   assign bus.count       = count_reg;
   assign bus.err         = err_reg;
endmodule
